// File: rtl/ramrwp_pkg.sv
// ramrwp_pkg -- shared types and helpers for the ramrwp_pipe storage block.
//   state_e   : controller states (ST_INIT clears memory, ST_READY serves accesses)
//   nbe_of    : number of byte lanes for a given data width / lane width
//   byte_par  : even-parity bit per byte lane
// Optional feature macro used by the block: RAMRWP_PARITY_EN.
package ramrwp_pkg;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Upper bounds for the generic parity helper; callers zero-extend their
  // data to MAX_WIDTH and truncate the result to their own lane count.
  localparam int MAX_WIDTH = 256;
  localparam int MAX_NBE   = 32;

  function automatic int nbe_of(input int width, input int bytew);
    return width / bytew;
  endfunction

  // Each result bit makes its lane plus that bit hold an even number of ones.
  function automatic logic [MAX_NBE-1:0] byte_par(input logic [MAX_WIDTH-1:0] data,
                                                  input int bytew, input int nbe);
    logic [MAX_NBE-1:0] p;
    p = '0;
    for (int b = 0; b < MAX_WIDTH; b++) begin
      if (b < nbe * bytew) p[5'(b / bytew)] = p[5'(b / bytew)] ^ data[8'(b)];
    end
    return p;
  endfunction

endpackage

// File: rtl/ramrwp_if.sv
// ramrwp_if -- access bus of the ramrwp_pipe RAM.
//   master modport: the client (drives addresses, strobes, write data)
//   slave modport : the RAM (drives dout, dvld, coll, rdy)
//   wa/we/wbe/di : write address, strobe, byte enables, data
//   ra/re        : read address, strobe
//   test/mask    : test=1 blocks reads and writes, mask=1 blocks reads
//   dout/dvld    : read data and its valid flag
//   coll         : returned read collided with a same-cycle write
//   rdy          : RAM accepts accesses
// With RAMRWP_PARITY_EN defined: pinj (inject parity error on write),
// perr (parity error with dvld), perr_stk (sticky parity error).
interface ramrwp_if
  import ramrwp_pkg::*;
#(
  parameter int ADDRBIT = 9,
  parameter int WIDTH   = 32,
  parameter int BYTEW   = 8
);
  localparam int NBE = nbe_of(WIDTH, BYTEW);

  logic [ADDRBIT-1:0] wa;
  logic               we;
  logic [NBE-1:0]     wbe;
  logic [WIDTH-1:0]   di;
  logic [ADDRBIT-1:0] ra;
  logic               re;
  logic               test;
  logic               mask;
  logic [WIDTH-1:0]   dout;
  logic               dvld;
  logic               coll;
  logic               rdy;

`ifdef RAMRWP_PARITY_EN
  logic pinj;
  logic perr;
  logic perr_stk;

  modport master (output wa, we, wbe, di, ra, re, test, mask, pinj,
                  input  dout, dvld, coll, rdy, perr, perr_stk);
  modport slave  (input  wa, we, wbe, di, ra, re, test, mask, pinj,
                  output dout, dvld, coll, rdy, perr, perr_stk);
`else
  modport master (output wa, we, wbe, di, ra, re, test, mask,
                  input  dout, dvld, coll, rdy);
  modport slave  (input  wa, we, wbe, di, ra, re, test, mask,
                  output dout, dvld, coll, rdy);
`endif

endinterface

// File: rtl/ramrwp_core.sv
// ramrwp_core -- plain storage array, one memory per byte lane.
//   clk         : clock
//   we/wa/wbe/wd: write strobe, address, lane enables, packed lane data
//   re/ra       : read strobe and address
//   rd          : registered read data (old contents on same-address write)
// No reset: contents are defined only by writes.
module ramrwp_core #(
  parameter int ADDRBIT = 9,
  parameter int DEPTH   = 512,
  parameter int NBE     = 4,
  parameter int LANEW   = 8
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [ADDRBIT-1:0]     wa,
  input  logic [NBE-1:0]         wbe,
  input  logic [NBE*LANEW-1:0]   wd,
  input  logic                   re,
  input  logic [ADDRBIT-1:0]     ra,
  output logic [NBE*LANEW-1:0]   rd
);

  for (genvar gi = 0; gi < NBE; gi++) begin : g_lane
    logic [LANEW-1:0] mem [DEPTH];
    logic [LANEW-1:0] rd_reg;

    always_ff @(posedge clk) begin
      if (we && wbe[gi]) mem[wa] <= wd[gi*LANEW +: LANEW];
      if (re) rd_reg <= mem[ra];
    end

    assign rd[gi*LANEW +: LANEW] = rd_reg;
  end

endmodule

// File: rtl/ramrwp_pipe.sv
// ramrwp_pipe -- single-clock RAM with byte-enable writes, write-to-read
// bypass, 1- or 2-cycle read pipeline with data-valid, and memory clearing
// after reset.
//   clk : clock
//   rst : asynchronous active-high reset (memory contents untouched)
//   bus : ramrwp_if.slave access port
// Optional macro RAMRWP_PARITY_EN adds per-lane even parity with
// pinj/perr/perr_stk on the bus.
module ramrwp_pipe
  import ramrwp_pkg::*;
#(
  parameter int    ADDRBIT  = 9,
  parameter int    DEPTH    = 512,
  parameter int    WIDTH    = 32,
  parameter int    BYTEW    = 8,
  parameter int    RDLAT    = 1,
  parameter string BYPASS   = "ON",
  parameter string INIT_CLR = "ON"
) (
  input logic      clk,
  input logic      rst,
  ramrwp_if.slave  bus
);

  localparam int NBE = nbe_of(WIDTH, BYTEW);
`ifdef RAMRWP_PARITY_EN
  localparam int LANEW = BYTEW + 1;
`else
  localparam int LANEW = BYTEW;
`endif
  localparam logic [0:0] S_INIT  = 1'(ST_INIT);
  localparam logic [0:0] S_READY = 1'(ST_READY);
  localparam bit CLR_ON = (INIT_CLR == "ON");
  localparam bit BYP_ON = (BYPASS == "ON");
  localparam logic [ADDRBIT-1:0] LAST = ADDRBIT'(DEPTH - 1);

  logic [0:0]           state_reg, state_next;
  logic [ADDRBIT-1:0]   icnt_reg, icnt_next;
  logic                 ready, init_wr, wr, rd, hit;
  logic                 c_we;
  logic [ADDRBIT-1:0]   c_wa;
  logic [NBE-1:0]       c_wbe;
  logic [NBE*LANEW-1:0] c_wd, c_rd;
  logic [WIDTH-1:0]     raw, merged;
  logic                 s1_vld_reg, s1_coll_reg;
  logic [NBE-1:0]       s1_be_reg;
  logic [WIDTH-1:0]     s1_di_reg;
`ifdef RAMRWP_PARITY_EN
  logic [NBE-1:0]       wpar, rpar_st, rpar_calc;
  logic                 perr1, perr_out, perr_stk_reg;
`endif

  // Init controller: with clearing disabled, ST_INIT lasts exactly one cycle.
  always_comb begin
    state_next = state_reg;
    icnt_next  = icnt_reg;
    if (state_reg == S_INIT) begin
      if (!CLR_ON || icnt_reg == LAST) state_next = S_READY;
      else icnt_next = icnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_INIT;
      icnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      icnt_reg  <= icnt_next;
    end
  end

  assign ready   = (state_reg == S_READY);
  assign init_wr = CLR_ON && (state_reg == S_INIT);
  assign wr      = ready & bus.we & ~bus.test;
  assign rd      = ready & bus.re & ~bus.mask & ~bus.test;
  assign hit     = wr & rd & (bus.ra == bus.wa);

  assign c_we  = init_wr | wr;
  assign c_wa  = init_wr ? icnt_reg : bus.wa;
  assign c_wbe = init_wr ? '1 : bus.wbe;

`ifdef RAMRWP_PARITY_EN
  assign wpar = NBE'(byte_par(MAX_WIDTH'(bus.di), BYTEW, NBE)) ^ {NBE{bus.pinj}};
`endif

  // Lane packing: stored lane = {parity, data} when parity is enabled.
  // Clearing writes all-zero lanes, whose even parity is also zero.
  for (genvar gi = 0; gi < NBE; gi++) begin : g_pack
    logic [LANEW-1:0] lane_w;
`ifdef RAMRWP_PARITY_EN
    assign lane_w      = {wpar[gi], bus.di[gi*BYTEW +: BYTEW]};
    assign rpar_st[gi] = c_rd[gi*LANEW + BYTEW];
`else
    assign lane_w      = bus.di[gi*BYTEW +: BYTEW];
`endif
    assign c_wd[gi*LANEW +: LANEW]   = init_wr ? '0 : lane_w;
    assign raw[gi*BYTEW +: BYTEW]    = c_rd[gi*LANEW +: BYTEW];
    assign merged[gi*BYTEW +: BYTEW] = s1_be_reg[gi] ? s1_di_reg[gi*BYTEW +: BYTEW]
                                                     : raw[gi*BYTEW +: BYTEW];
  end

  ramrwp_core #(
    .ADDRBIT (ADDRBIT),
    .DEPTH   (DEPTH),
    .NBE     (NBE),
    .LANEW   (LANEW)
  ) u_core (
    .clk (clk),
    .we  (c_we),
    .wa  (c_wa),
    .wbe (c_wbe),
    .wd  (c_wd),
    .re  (rd),
    .ra  (bus.ra),
    .rd  (c_rd)
  );

  // Stage 1 runs alongside the core's registered read. The core returns
  // old data on a collision; s1_be_reg selects the lanes to take from di.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_reg  <= 1'b0;
      s1_coll_reg <= 1'b0;
      s1_be_reg   <= '0;
      s1_di_reg   <= '0;
    end else begin
      s1_vld_reg  <= rd;
      s1_coll_reg <= hit;
      s1_be_reg   <= (BYP_ON && hit) ? bus.wbe : '0;
      s1_di_reg   <= bus.di;
    end
  end

`ifdef RAMRWP_PARITY_EN
  // Bypassed lanes never came from storage, so they are excluded.
  assign rpar_calc = NBE'(byte_par(MAX_WIDTH'(raw), BYTEW, NBE));
  assign perr1     = s1_vld_reg & |((rpar_calc ^ rpar_st) & ~s1_be_reg);
`endif

  if (RDLAT == 2) begin : g_lat2
    logic             s2_vld_reg, s2_coll_reg;
    logic [WIDTH-1:0] s2_do_reg;
`ifdef RAMRWP_PARITY_EN
    logic             s2_perr_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) s2_perr_reg <= 1'b0;
      else     s2_perr_reg <= perr1;
    end
    assign perr_out = s2_perr_reg;
`endif
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_vld_reg  <= 1'b0;
        s2_coll_reg <= 1'b0;
        s2_do_reg   <= '0;
      end else begin
        s2_vld_reg  <= s1_vld_reg;
        s2_coll_reg <= s1_coll_reg;
        if (s1_vld_reg) s2_do_reg <= merged;
      end
    end
    assign bus.dout = s2_do_reg;
    assign bus.dvld = s2_vld_reg;
    assign bus.coll = s2_coll_reg;
  end else begin : g_lat1
    // Result comes straight from the core; hold_reg keeps dout stable
    // (and zero after reset) while no result is being presented.
    logic [WIDTH-1:0] hold_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)             hold_reg <= '0;
      else if (s1_vld_reg) hold_reg <= merged;
    end
    assign bus.dout = s1_vld_reg ? merged : hold_reg;
    assign bus.dvld = s1_vld_reg;
    assign bus.coll = s1_coll_reg;
`ifdef RAMRWP_PARITY_EN
    assign perr_out = perr1;
`endif
  end

`ifdef RAMRWP_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           perr_stk_reg <= 1'b0;
    else if (perr_out) perr_stk_reg <= 1'b1;
  end
  assign bus.perr     = perr_out;
  assign bus.perr_stk = perr_stk_reg;
`endif

  assign bus.rdy = ready;

endmodule
